gpmc_regbank: RTL

GPMC_REGBANK -- requirements
Module: gpmc_regbank

---
 rtl/gpmc_defs.sv | 27 ++
 rtl/gpmc_oneshot.sv | 24 ++
 rtl/gpmc_regbank.sv | 93 +++++++++
 3 files changed

// File: rtl/gpmc_defs.sv
// Shared GPMC bus-decode definitions: access-type encoding, default widths and
// the cs/we/oe decode used by gpmc_regbank and gpmc_sync.
package gpmc_defs;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        ACC_IDLE  = 2'd0,
        ACC_WRITE = 2'd1,
        ACC_READ  = 2'd2
    } acc_t;

    // All strobes are active-low; any combination other than a clean write or
    // a clean read (including all three low) is treated as idle.
    function automatic acc_t decode_access(input logic cs, input logic we, input logic oe);
        acc_t acc;
        acc = ACC_IDLE;
        if (!cs && !we && oe) begin
            acc = ACC_WRITE;
        end else if (!cs && we && !oe) begin
            acc = ACC_READ;
        end
        return acc;
    endfunction

endpackage

// File: rtl/gpmc_oneshot.sv
// One-shot access detector: fires on the first cycle of an access and stays
// disarmed until a cycle without the access re-arms it.
module gpmc_oneshot (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    output logic fire
);

    logic armed;

    // Reset leaves the detector disarmed so a strobe still asserted when reset
    // is released cannot fire until the bus has gone inactive once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            armed <= 1'b0;
        end else begin
            armed <= !active;
        end
    end

    assign fire = active && armed;

endmodule

// File: rtl/gpmc_regbank.sv
// GPMC register bank: read-write control registers, read-only status registers,
// per-register write/read strobes. Optional macro GPMC_REGBANK_SELFCLR_EN.
module gpmc_regbank
    import gpmc_defs::*;
#(
    parameter int                    DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int                    ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int                    NUM_CTRL     = 8,
    parameter int                    NUM_STAT     = 4,
    parameter logic [DATA_WIDTH-1:0] SELFCLR_MASK = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cs,
    input  logic                           we,
    input  logic                           oe,
    input  logic [ADDR_WIDTH-1:0]          address,
    input  logic [DATA_WIDTH-1:0]          data_out,
    output logic [DATA_WIDTH-1:0]          data_in,
    output logic [NUM_CTRL*DATA_WIDTH-1:0] ctrl,
    output logic [NUM_CTRL-1:0]            wr_pulse,
    input  logic [NUM_STAT*DATA_WIDTH-1:0] stat,
    output logic [NUM_STAT-1:0]            rd_pulse
);

    acc_t                  acc;
    logic                  wr_fire;
    logic                  rd_fire;
    logic [DATA_WIDTH-1:0] regs [NUM_CTRL];
    logic [DATA_WIDTH-1:0] rd_mux;

    assign acc = decode_access(cs, we, oe);

    gpmc_oneshot u_wr_shot (
        .clk    (clk),
        .rst_n  (rst_n),
        .active (acc == ACC_WRITE),
        .fire   (wr_fire)
    );

    gpmc_oneshot u_rd_shot (
        .clk    (clk),
        .rst_n  (rst_n),
        .active (acc == ACC_READ),
        .fire   (rd_fire)
    );

    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < NUM_CTRL; k++) begin
            if (address == ADDR_WIDTH'(k)) rd_mux = regs[k];
        end
        for (int i = 0; i < NUM_STAT; i++) begin
            if (address == ADDR_WIDTH'(NUM_CTRL + i)) rd_mux = stat[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CTRL; k++) regs[k] <= '0;
            wr_pulse <= '0;
            rd_pulse <= '0;
            data_in  <= '0;
        end else begin
            wr_pulse <= '0;
            rd_pulse <= '0;
            data_in  <= (acc == ACC_READ) ? rd_mux : '0;
`ifdef GPMC_REGBANK_SELFCLR_EN
            // Clear in the cycle the write strobe is visible; a commit below wins.
            if (wr_pulse[0]) regs[0] <= regs[0] & ~SELFCLR_MASK;
`endif
            for (int k = 0; k < NUM_CTRL; k++) begin
                if (wr_fire && address == ADDR_WIDTH'(k)) begin
                    regs[k]     <= data_out;
                    wr_pulse[k] <= 1'b1;
                end
            end
            for (int i = 0; i < NUM_STAT; i++) begin
                if (rd_fire && address == ADDR_WIDTH'(NUM_CTRL + i)) rd_pulse[i] <= 1'b1;
            end
        end
    end

`ifndef GPMC_REGBANK_SELFCLR_EN
    logic unused_selfclr_mask;
    assign unused_selfclr_mask = ^SELFCLR_MASK;
`endif

    for (genvar k = 0; k < NUM_CTRL; k++) begin : g_ctrl
        assign ctrl[k*DATA_WIDTH +: DATA_WIDTH] = regs[k];
    end

endmodule
